// File: rtl/pipe_scroller_pkg.sv
// Shared definitions for the pipe field: state encoding, coordinate type and default geometry.
// Also used by the height table and the renderer.
package pipe_scroller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  localparam int unsigned NUM_SLOTS = 5;
  localparam int unsigned COORD_W   = 12;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned SCORE_W   = 8;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_PIPE_W   = 60;
  localparam int DEF_SPACING  = 160;
  localparam int DEF_BIRD_X   = 100;

  typedef logic signed [COORD_W-1:0] coord_t;

  // Spawn X of slot k at reset or restart.
  function automatic coord_t spawn_x(input int k, input int screen_w, input int spacing);
    return coord_t'(screen_w + k * spacing);
  endfunction

endpackage

// File: rtl/pipe_scroller_if.sv
// Control inputs and field outputs of the pipe scroller.
// The game controller is the master; the scroller is the slave.
interface pipe_scroller_if;
  import pipe_scroller_pkg::*;

  logic               frame_tick;
  logic               start;
  logic               crash;
  coord_t             x0;
  coord_t             x1;
  coord_t             x2;
  coord_t             x3;
  coord_t             x4;
  logic [IDX_W-1:0]   rom_idx;
  logic [IDX_W-1:0]   coin_idx;
  logic               shift_pulse;
  logic               score_pulse;
  logic [SCORE_W-1:0] score;
  logic [1:0]         state;

  modport master (
    output frame_tick, start, crash,
    input  x0, x1, x2, x3, x4, rom_idx, coin_idx,
    input  shift_pulse, score_pulse, score, state
  );

  modport slave (
    input  frame_tick, start, crash,
    output x0, x1, x2, x3, x4, rom_idx, coin_idx,
    output shift_pulse, score_pulse, score, state
  );

endinterface

// File: rtl/pipe_scroller_mod5_counter.sv
// Three-bit counter wrapping 4 -> 0, with enable and synchronous clear.
// nxt_c_o exposes the next value so a mirror register can track q_o exactly.
module mod5_counter
  import pipe_scroller_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [IDX_W-1:0] q_o,
  output logic [IDX_W-1:0] nxt_c_o
);

  localparam logic [IDX_W-1:0] WRAP_AT = IDX_W'(NUM_SLOTS - 1);

  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == WRAP_AT) ? '0 : cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign q_o     = cnt_q;
  assign nxt_c_o = cnt_d;

endmodule

// File: rtl/pipe_scroller.sv
// Scrolls five pipe slots left per frame tick, rotates them as slot 0 exits,
// and scores each pipe the bird clears.
module pipe_scroller
  import pipe_scroller_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int PIPE_W   = DEF_PIPE_W,
  parameter int SPACING  = DEF_SPACING,
  parameter int SPEED    = 2,
  parameter int BIRD_X   = DEF_BIRD_X
) (
  input logic             clk,
  input logic             reset,
  pipe_scroller_if.slave  bus
);

  localparam coord_t SPEED_C   = coord_t'(SPEED);
  localparam coord_t PIPE_W_C  = coord_t'(PIPE_W);
  localparam coord_t SPACING_C = coord_t'(SPACING);
  localparam coord_t BIRD_X_C  = coord_t'(BIRD_X);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_e             state_q;
  coord_t             x_q [NUM_SLOTS];
  logic [SCORE_W-1:0] score_q;
  logic               scored_q;
  logic               pending_q;
  logic               score_pulse_q;
  logic               shift_pulse_q;
  logic [IDX_W-1:0]   coin_idx_q;
  logic [IDX_W-1:0]   rom_idx;
  logic [IDX_W-1:0]   rom_idx_nxt;

  logic   advance_c;
  coord_t x0_next_c;
  coord_t x0_edge_c;

  // A tick parked during SHIFT counts as a tick on the following SCROLL cycle.
  assign advance_c = bus.frame_tick | pending_q;
  assign x0_next_c = x_q[0] - SPEED_C;
  assign x0_edge_c = x0_next_c + PIPE_W_C;

  mod5_counter u_rom_idx (
    .clk     (clk),
    .reset   (reset),
    .en_i    (state_q == ST_SHIFT),
    .clr_i   ((state_q == ST_HALT) && bus.start),
    .q_o     (rom_idx),
    .nxt_c_o (rom_idx_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      for (int k = 0; k < NUM_SLOTS; k++) x_q[k] <= spawn_x(k, SCREEN_W, SPACING);
      score_q       <= '0;
      scored_q      <= 1'b0;
      pending_q     <= 1'b0;
      score_pulse_q <= 1'b0;
      shift_pulse_q <= 1'b0;
      coin_idx_q    <= '0;
    end else begin
      score_pulse_q <= 1'b0;
      shift_pulse_q <= 1'b0;
      coin_idx_q    <= rom_idx_nxt;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) state_q <= ST_SCROLL;
        end
        ST_SCROLL: begin
          if (bus.crash) begin
            state_q <= ST_HALT;
          end else if (advance_c) begin
            for (int k = 0; k < NUM_SLOTS; k++) x_q[k] <= x_q[k] - SPEED_C;
            pending_q <= 1'b0;
            if (!scored_q && (x0_edge_c < BIRD_X_C)) begin
              score_pulse_q <= 1'b1;
              scored_q      <= 1'b1;
              if (score_q != SCORE_MAX) score_q <= score_q + SCORE_W'(1);
            end
            if (x0_edge_c <= coord_t'(0)) state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          for (int k = 0; k < NUM_SLOTS - 1; k++) x_q[k] <= x_q[k+1];
          x_q[NUM_SLOTS-1] <= x_q[NUM_SLOTS-1] + SPACING_C;
          shift_pulse_q    <= 1'b1;
          scored_q         <= 1'b0;
          if (bus.crash) begin
            state_q <= ST_HALT;
          end else begin
            state_q <= ST_SCROLL;
            if (bus.frame_tick) pending_q <= 1'b1;
          end
        end
        ST_HALT: begin
          if (bus.start) begin
            for (int k = 0; k < NUM_SLOTS; k++) x_q[k] <= spawn_x(k, SCREEN_W, SPACING);
            score_q   <= '0;
            scored_q  <= 1'b0;
            pending_q <= 1'b0;
            state_q   <= ST_SCROLL;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.x0          = x_q[0];
  assign bus.x1          = x_q[1];
  assign bus.x2          = x_q[2];
  assign bus.x3          = x_q[3];
  assign bus.x4          = x_q[4];
  assign bus.rom_idx     = rom_idx;
  assign bus.coin_idx    = coin_idx_q;
  assign bus.shift_pulse = shift_pulse_q;
  assign bus.score_pulse = score_pulse_q;
  assign bus.score       = score_q;
  assign bus.state       = state_q;

endmodule
